// File: rtl/load_store_unit.sv
// Memory-access stage: one load or store per request over a req/ready handshake,
// with lane steering, load extension, and misaligned/illegal/timeout fault reporting.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic [1:0]  fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_is_store;
  logic [2:0]       r_funct3;
  logic [1:0]       r_off;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_fault;
  logic [31:0]      r_load_data;
  logic             r_mem_req;
  logic             r_mem_we;
  logic [31:0]      r_mem_addr;
  logic [31:0]      r_mem_wdata;
  logic [3:0]       r_mem_wmask;

  logic             w_illegal;
  logic             w_misal;
  logic             w_ok;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_timeout;

  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] sd);
    case (f3[1:0])
      2'd0:    lane_wdata = {4{sd[7:0]}};
      2'd1:    lane_wdata = {2{sd[15:0]}};
      default: lane_wdata = sd;
    endcase
  endfunction

  function automatic logic [3:0] lane_wmask(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'd0:    lane_wmask = 4'b0001 << off;
      2'd1:    lane_wmask = 4'b0011 << off;
      default: lane_wmask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] rdata);
    logic [31:0] sh;
    sh = rdata >> {off, 3'b000};
    case (f3)
      3'd0:    load_extend = {{24{sh[7]}}, sh[7:0]};
      3'd4:    load_extend = {24'd0, sh[7:0]};
      3'd1:    load_extend = {{16{sh[15]}}, sh[15:0]};
      3'd5:    load_extend = {16'd0, sh[15:0]};
      default: load_extend = rdata;
    endcase
  endfunction

  // Request decode on the live inputs; only meaningful at the accepting edge in IDLE.
  assign w_illegal = is_store ? (funct3 > 3'd2)
                              : (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7);
  assign w_misal   = ((funct3[1:0] == 2'd1) && addr[0]) ||
                     ((funct3[1:0] == 2'd2) && (addr[1:0] != 2'b00));
  assign w_ok      = !w_illegal && !w_misal;
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = w_ok ? S_ACCESS : S_RESP;
      S_ACCESS: if (mem_ready || w_timeout) w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_is_store  <= 1'b0;
      r_funct3    <= 3'd0;
      r_off       <= 2'd0;
      r_cnt       <= '0;
      r_fault     <= 2'b00;
      r_load_data <= 32'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_wmask <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_is_store  <= is_store;
            r_funct3    <= funct3;
            r_off       <= addr[1:0];
            r_cnt       <= '0;
            r_load_data <= 32'd0;
            r_fault     <= w_illegal ? 2'b11 : (w_misal ? 2'b01 : 2'b00);
            r_mem_req   <= w_ok;
            r_mem_we    <= w_ok && is_store;
            r_mem_addr  <= {addr[31:2], 2'b00};
            r_mem_wdata <= (w_ok && is_store) ? lane_wdata(funct3, store_data) : 32'd0;
            r_mem_wmask <= (w_ok && is_store) ? lane_wmask(funct3, addr[1:0]) : 4'd0;
          end
        end
        S_ACCESS: begin
          // Ready wins over a timeout landing on the same cycle.
          if (mem_ready) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_fault     <= 2'b00;
            r_load_data <= r_is_store ? 32'd0 : load_extend(r_funct3, r_off, mem_rdata);
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_timeout) begin
              r_mem_req   <= 1'b0;
              r_mem_we    <= 1'b0;
              r_fault     <= 2'b10;
              r_load_data <= 32'd0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_RESP);
  assign load_data = r_load_data;
  assign fault     = r_fault;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wmask = r_mem_wmask;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a transaction-level model sets per-cycle
// expectations that one negedge compare process checks against the DUT.
module tb_load_store_unit;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic [1:0]  fault;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  load_store_unit #(.TIMEOUT_CYCLES(TMO), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .store_data(store_data), .busy(busy), .done(done),
    .load_data(load_data), .fault(fault), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  bit          chk_en = 0;
  bit          e_busy, e_req, e_done, e_st, e_we, res_vld;
  logic [31:0] e_maddr, e_wd, e_ld;
  logic [3:0]  e_wm;
  logic [1:0]  e_fault;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: outcome of one request from the architectural rules.
  function automatic void model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] sd, input logic [31:0] rd,
                                output logic [1:0] flt, output logic [31:0] ld,
                                output logic [31:0] wd, output logic [3:0] wm, output bit we);
    int size, off;
    bit illegal, uns;
    longint v;
    illegal = st ? !(f3 inside {3'd0, 3'd1, 3'd2}) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size = (f3 % 4 == 0) ? 1 : ((f3 % 4 == 1) ? 2 : 4);
    off  = int'(a % 4);
    uns  = (f3 >= 3'd4);
    flt  = illegal ? 2'd3 : ((a % size != 0) ? 2'd1 : 2'd0);
    ld = 0; wd = 0; wm = 0; we = 0;
    if (st) begin
      we = 1;
      wm = 4'(((1 << size) - 1) << off);
      if (size == 1)      wd = (sd & 32'hFF)   * 32'h01010101;
      else if (size == 2) wd = (sd & 32'hFFFF) * 32'h00010001;
      else                wd = sd;
    end else begin
      v = {32'd0, rd};
      v = v >> (8 * off);
      v = v % (longint'(1) << (8 * size));
      if (!uns && size < 4 && v >= (longint'(1) << (8 * size - 1)))
        v = v - (longint'(1) << (8 * size));
      ld = v[31:0];
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(e_busy));
      chk("mem_req", 32'(mem_req), 32'(e_req));
      chk("done", 32'(done), 32'(e_done));
      if (e_req) begin
        chk("mem_addr", mem_addr, e_maddr);
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_wmask", 32'(mem_wmask), 32'(e_wm));
        if (e_st) chk("mem_wdata", mem_wdata, e_wd);
      end
      if (res_vld) begin
        chk("fault", 32'(fault), 32'(e_fault));
        chk("load_data", load_data, e_ld);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input bit b, input bit r, input bit d);
    e_busy = b; e_req = r; e_done = d;
  endtask

  task automatic do_txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rd,
                        input int waits, input bit tmo);
    logic [1:0]  flt;
    logic [31:0] ld, wd;
    logic [3:0]  wm;
    bit          we;
    int          nacc;
    model(st, f3, a, sd, rd, flt, ld, wd, wm, we);
    if (tmo) begin flt = 2'd2; ld = 32'd0; end
    start = 1; is_store = st; funct3 = f3; addr = a; store_data = sd;
    step();
    start = 0; is_store = 1'($urandom); funct3 = 3'($urandom);
    addr = $urandom; store_data = $urandom;
    res_vld = 0;
    if (flt == 2'd1 || flt == 2'd3) begin
      set_exp(1, 0, 1); e_fault = flt; e_ld = ld; res_vld = 1;
    end else begin
      e_maddr = {a[31:2], 2'b00}; e_wd = wd; e_wm = wm; e_we = we; e_st = st;
      nacc = tmo ? TMO : waits + 1;
      for (int i = 0; i < nacc; i++) begin
        set_exp(1, 1, 0);
        mem_ready = (!tmo && i == nacc - 1);
        mem_rdata = mem_ready ? rd : $urandom;
        step();
      end
      mem_ready = 0; mem_rdata = $urandom;
      set_exp(1, 0, 1); e_fault = flt; e_ld = ld; res_vld = 1;
    end
    if (tmo) begin start = 1; is_store = 0; funct3 = 3'd2; addr = 32'h40; end
    step();
    start = 0;
    set_exp(0, 0, 0);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  m_flt;
    logic [31:0] m_ld, m_wd;
    logic [3:0]  m_wm;
    bit          m_we;

    reset = 1; start = 0; is_store = 0; funct3 = 0; addr = 0; store_data = 0;
    mem_ready = 0; mem_rdata = 0;
    set_exp(0, 0, 0); res_vld = 0; e_st = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    @(negedge clk); #1 reset = 0;
    e_fault = 0; e_ld = 0; res_vld = 1;
    step();
    chk_en = 1;

    // Model pins from hand computation
    model(0, 3'd0, 32'h203, 0, 32'h80112233, m_flt, m_ld, m_wd, m_wm, m_we);
    chk("pin_lb", m_ld, 32'hFFFFFF80);
    model(1, 3'd1, 32'h10E, 32'h0000ABCD, 0, m_flt, m_ld, m_wd, m_wm, m_we);
    chk("pin_sh_wdata", m_wd, 32'hABCDABCD);
    chk("pin_sh_wmask", 32'(m_wm), 32'h0000000C);

    do_txn(0, 3'd2, 32'h100, 0, 32'hDEADBEEF, 0, 0);
    chk("lit_lw", load_data, 32'hDEADBEEF);
    do_txn(0, 3'd0, 32'h203, 0, 32'h80112233, 0, 0);
    chk("lit_lb", load_data, 32'hFFFFFF80);
    do_txn(0, 3'd4, 32'h203, 0, 32'h80112233, 1, 0);
    chk("lit_lbu", load_data, 32'h00000080);
    do_txn(0, 3'd1, 32'h202, 0, 32'h80112233, 0, 0);
    do_txn(0, 3'd5, 32'h202, 0, 32'h80112233, 2, 0);
    do_txn(1, 3'd1, 32'h10E, 32'h0000ABCD, 0, 3, 0);
    chk("lit_sh_ld", load_data, 32'd0);
    do_txn(1, 3'd0, 32'h55, 32'h12345678, 0, 1, 0);
    do_txn(1, 3'd2, 32'h80, 32'hCAFEF00D, 0, 0, 0);
    do_txn(0, 3'd2, 32'h102, 0, 0, 0, 0);
    chk("lit_misal", 32'(fault), 32'd1);
    do_txn(0, 3'd1, 32'h101, 0, 0, 0, 0);
    do_txn(1, 3'd3, 32'h100, 32'h1, 0, 0, 0);
    chk("lit_illegal", 32'(fault), 32'd3);
    do_txn(0, 3'd6, 32'h100, 0, 0, 0, 0);
    do_txn(0, 3'd2, 32'h400, 0, 32'h11111111, 0, 1);
    chk("lit_tmo_fault", 32'(fault), 32'd2);
    chk("lit_tmo_ld", load_data, 32'd0);

    // Reset asserted in the second wait cycle of an access
    start = 1; is_store = 0; funct3 = 3'd2; addr = 32'h300;
    step();
    start = 0; res_vld = 0; mem_ready = 0;
    set_exp(1, 1, 0); e_maddr = 32'h300; e_we = 0; e_wm = 0; e_st = 0;
    step();
    @(negedge clk); #1;
    chk_en = 0; reset = 1;
    #1;
    chk("rstmid_mem_req", 32'(mem_req), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_done", 32'(done), 32'd0);
    set_exp(0, 0, 0); e_fault = 0; e_ld = 0; res_vld = 1;
    step();
    chk_en = 1;
    step();
    @(negedge clk); #1 reset = 0;
    step();
    do_txn(0, 3'd2, 32'h300, 0, 32'h0BADF00D, 1, 0);
    chk("lit_after_rst", load_data, 32'h0BADF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage directly downstream of the execute ALU. It consumes the ALU result as an effective address, plus rs2 data and the decoded funct3/store flag, and performs one load or store per request against the data memory over a req/ready handshake. It returns aligned, sign- or zero-extended load data for writeback. It also reports misalignment, illegal width, or bus-timeout faults, and exposes a busy signal so fetch/decode can stall.

Parameters:
TIMEOUT_CYCLES, 16, max cycles waiting for mem_ready in ACCESS before faulting; 0 disables the timeout.
CNT_W, 5, width of the wait counter; must hold TIMEOUT_CYCLES.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request strobe, sampled only in IDLE
is_store  in  1  1 = store, 0 = load
funct3  in  3  RV32I width/sign code
addr  in  32  byte effective address (ALU_out)
store_data  in  32  rs2 value
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle completion pulse
load_data  out  32  extended load result, held until the next accepted start
fault  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal funct3; valid with done
mem_req  out  1  memory request, registered
mem_we  out  1  write enable, valid with mem_req
mem_addr  out  32  {addr[31:2],2'b00}
mem_wdata  out  32  lane-replicated store data
mem_wmask  out  4  byte strobes
mem_ready  in  1  memory accepts/completes the request this cycle
mem_rdata  in  32  read word, valid when mem_ready=1

Behaviour:
- Async reset, applied immediately: state=IDLE; all outputs 0; wait counter 0. A reset during ACCESS drops mem_req combinationally with no completion pulse.
- Request capture: all request inputs (start, is_store, funct3, addr, store_data) are registered at the accepting edge. Inputs are don't-care afterwards.
- IDLE:
  - start=1 with illegal funct3 -> RESP, fault=11. Illegal loads are 3, 6, 7; illegal stores are 3–7.
  - start=1 with misaligned address -> RESP, fault=01. Misaligned means halfword with addr[0]=1, or word with addr[1:0]≠0.
  - Otherwise -> ACCESS, with mem_req=1 from the next cycle.
  - Faulted requests never assert mem_req.
- ACCESS:
  - mem_req, mem_we, mem_addr, mem_wdata and mem_wmask are held stable until mem_ready=1 is sampled.
  - On mem_ready=1: capture mem_rdata (loads) -> RESP, fault=00. mem_req deasserts in RESP.
  - Wait counter increments each ACCESS cycle with mem_ready=0. When it equals TIMEOUT_CYCLES (and TIMEOUT_CYCLES≠0) -> RESP, fault=10, load_data=0.
- RESP: done=1 for exactly one cycle -> IDLE. start in RESP is ignored.
- start while busy: ignored and not queued.
- Latency: accepted start at edge N; mem_req high during cycle N+1. With mem_ready=1 in cycle N+1, done is high in cycle N+2. Minimum latency is 2 cycles; each mem_ready wait cycle adds 1.
- Store lanes, with off=addr[1:0]:
  - SB: wdata={4{sd[7:0]}}, wmask=0001<<off.
  - SH: wdata={2{sd[15:0]}}, wmask=0011<<off.
  - SW: wdata=sd, wmask=1111.
- Loads: byte = rdata >> (8*off).
  - LB/LBU: sign-/zero-extend byte[7:0].
  - LH/LHU: sign-/zero-extend byte[15:0].
  - LW: rdata.
  - mem_wmask=0000, mem_we=0 for all loads.
- Stores: load_data=0 at done.
- Faults: fault and load_data hold their values after done until the next accepted start.

Test Plan:
- Aligned LW, zero-wait: addr=0x100, mem_ready=1 at first req cycle, rdata=0xDEADBEEF -> mem_addr=0x100, done at N+2, load_data=0xDEADBEEF, fault=00.
- LB vs LBU at offset 3: addr=0x203, rdata=0x80112233 -> mem_addr=0x200. LB gives load_data=0xFFFFFF80; LBU gives 0x00000080.
- SH at offset 2, 3 wait cycles: store_data=0x0000ABCD, addr=0x10E -> mem_wdata=0xABCDABCD, wmask=1100, mem_we=1. mem_req and outputs are stable for 4 cycles; done arrives 1 cycle after mem_ready.
- Misaligned and illegal: LW addr=0x102 -> no mem_req, done at N+1, fault=01. Store funct3=3 -> fault=11.
- Timeout: mem_ready held 0, TIMEOUT_CYCLES=16 -> mem_req high for 16 cycles then low. done with fault=10, load_data=0; a second start in RESP is ignored.
- Reset mid-ACCESS: reset asserted in the 2nd wait cycle -> mem_req and busy drop immediately with no done. After release, a new LW completes normally.
